// File: rtl/axi_mem_responder.sv
// AXI4 responder backed by an on-chip byte-addressed array; independent single-outstanding read/write INCR engines.
// Optional build macro AXI_MEM_RESP_OOR_ERR_EN: beats addressed beyond MEM_BYTES are dropped/zeroed with SLVERR.
module axi_mem_responder #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 6,
  parameter int MEM_BYTES = 65536
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [ID_W-1:0]     aw_id_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [7:0]          aw_len_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic                w_last_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output logic [ID_W-1:0]     b_id_o,
  output logic [1:0]          b_resp_o,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [ID_W-1:0]     ar_id_i,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  input  logic [7:0]          ar_len_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [ID_W-1:0]     r_id_o,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_last_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int IDX_W  = MEM_AW - OFF_W;
  localparam int WA_W   = ADDR_W - OFF_W;
  localparam int WORDS  = MEM_BYTES / STRB_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  logic [DATA_W-1:0] mem_r [WORDS];

  w_state_t          w_state_r, w_state_nx_s;
  logic              aw_ready_r, w_ready_r, b_valid_r;
  logic [WA_W-1:0]   wr_waddr_r;
  logic [7:0]        wr_len_r, wr_beat_r;
  logic              wr_err_r;
  logic [ID_W-1:0]   b_id_r;
  logic [1:0]        b_resp_r;

  r_state_t          r_state_r, r_state_nx_s;
  logic              ar_ready_r, r_valid_r, r_last_r;
  logic [WA_W-1:0]   rd_waddr_r;
  logic [7:0]        rd_len_r, rd_beat_r;
  logic [ID_W-1:0]   r_id_r;
  logic [DATA_W-1:0] r_data_r;
  logic [1:0]        r_resp_r;

  logic              aw_fire_s, w_fire_s, b_fire_s, ar_fire_s, r_fire_s;
  logic              wr_last_beat_s, wr_beat_err_s, wr_oor_s, mem_we_s;
  logic              rd_load_s, rd_last_s, rd_oor_s;
  logic [WA_W-1:0]   rd_addr_s;
  logic              unused_addr_s;

  assign aw_fire_s = aw_valid_i & aw_ready_r;
  assign w_fire_s  = w_valid_i & w_ready_r;
  assign b_fire_s  = b_valid_r & b_ready_i;
  assign ar_fire_s = ar_valid_i & ar_ready_r;
  assign r_fire_s  = r_valid_r & r_ready_i;

  // Byte offsets are irrelevant: every beat is a full, aligned word.
  assign unused_addr_s = ^{aw_addr_i[OFF_W-1:0], ar_addr_i[OFF_W-1:0]};

`ifdef AXI_MEM_RESP_OOR_ERR_EN
  assign wr_oor_s = |wr_waddr_r[WA_W-1:IDX_W];
  assign rd_oor_s = |rd_addr_s[WA_W-1:IDX_W];
`else
  assign wr_oor_s = 1'b0;
  assign rd_oor_s = 1'b0;
`endif

  assign wr_last_beat_s = (wr_beat_r == wr_len_r);
  assign wr_beat_err_s  = (w_last_i != wr_last_beat_s) | wr_oor_s;
  assign mem_we_s       = w_fire_s & ~wr_oor_s;

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_i[b]) begin
          mem_r[wr_waddr_r[IDX_W-1:0]][b*8 +: 8] <= w_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Write engine next-state.
  always_comb begin
    w_state_nx_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_fire_s) w_state_nx_s = W_DATA; else w_state_nx_s = W_IDLE;
      W_DATA:  if (w_fire_s && wr_last_beat_s) w_state_nx_s = W_RESP; else w_state_nx_s = W_DATA;
      W_RESP:  if (b_fire_s) w_state_nx_s = W_IDLE; else w_state_nx_s = W_RESP;
      default: w_state_nx_s = W_IDLE;
    endcase
  end

  // Write engine state and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_r  <= W_IDLE;
      aw_ready_r <= 1'b1;
      w_ready_r  <= 1'b0;
      b_valid_r  <= 1'b0;
    end else begin
      w_state_r  <= w_state_nx_s;
      aw_ready_r <= (w_state_nx_s == W_IDLE);
      w_ready_r  <= (w_state_nx_s == W_DATA);
      b_valid_r  <= (w_state_nx_s == W_RESP);
    end
  end

  // Write burst tracking; an error on any beat sticks until the response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_waddr_r <= {WA_W{1'b0}};
      wr_len_r   <= 8'd0;
      wr_beat_r  <= 8'd0;
      wr_err_r   <= 1'b0;
      b_id_r     <= {ID_W{1'b0}};
      b_resp_r   <= RESP_OKAY;
    end else if (aw_fire_s) begin
      wr_waddr_r <= aw_addr_i[ADDR_W-1:OFF_W];
      wr_len_r   <= aw_len_i;
      wr_beat_r  <= 8'd0;
      wr_err_r   <= 1'b0;
      b_id_r     <= aw_id_i;
    end else if (w_fire_s) begin
      wr_waddr_r <= wr_waddr_r + {{(WA_W-1){1'b0}}, 1'b1};
      wr_beat_r  <= wr_beat_r + 8'd1;
      wr_err_r   <= wr_err_r | wr_beat_err_s;
      if (wr_last_beat_s) begin
        b_resp_r <= (wr_err_r | wr_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Read engine next-state and the word address of the beat to fetch.
  always_comb begin
    r_state_nx_s = r_state_r;
    rd_load_s    = 1'b0;
    rd_addr_s    = rd_waddr_r + {{(WA_W-1){1'b0}}, 1'b1};
    rd_last_s    = ((rd_beat_r + 8'd1) == rd_len_r);
    case (r_state_r)
      R_IDLE: begin
        if (ar_fire_s) begin
          r_state_nx_s = R_DATA;
          rd_load_s    = 1'b1;
          rd_addr_s    = ar_addr_i[ADDR_W-1:OFF_W];
          rd_last_s    = (ar_len_i == 8'd0);
        end else begin
          r_state_nx_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_fire_s && r_last_r) begin
          r_state_nx_s = R_IDLE;
        end else if (r_fire_s) begin
          rd_load_s = 1'b1;
        end else begin
          r_state_nx_s = R_DATA;
        end
      end
      default: r_state_nx_s = R_IDLE;
    endcase
  end

  // Read engine state, beat fetch and registered R channel.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state_r  <= R_IDLE;
      ar_ready_r <= 1'b1;
      r_valid_r  <= 1'b0;
      r_last_r   <= 1'b0;
      r_id_r     <= {ID_W{1'b0}};
      r_data_r   <= {DATA_W{1'b0}};
      r_resp_r   <= RESP_OKAY;
      rd_waddr_r <= {WA_W{1'b0}};
      rd_len_r   <= 8'd0;
      rd_beat_r  <= 8'd0;
    end else begin
      r_state_r  <= r_state_nx_s;
      ar_ready_r <= (r_state_nx_s == R_IDLE);
      if (ar_fire_s) begin
        r_id_r   <= ar_id_i;
        rd_len_r <= ar_len_i;
      end
      if (rd_load_s) begin
        rd_waddr_r <= rd_addr_s;
        rd_beat_r  <= ar_fire_s ? 8'd0 : (rd_beat_r + 8'd1);
        r_data_r   <= rd_oor_s ? {DATA_W{1'b0}} : mem_r[rd_addr_s[IDX_W-1:0]];
        r_resp_r   <= rd_oor_s ? RESP_SLVERR : RESP_OKAY;
        r_last_r   <= rd_last_s;
        r_valid_r  <= 1'b1;
      end else if (r_fire_s) begin
        r_valid_r <= 1'b0;
        r_last_r  <= 1'b0;
      end
    end
  end

  assign aw_ready_o = aw_ready_r;
  assign w_ready_o  = w_ready_r;
  assign b_valid_o  = b_valid_r;
  assign b_id_o     = b_id_r;
  assign b_resp_o   = b_resp_r;
  assign ar_ready_o = ar_ready_r;
  assign r_valid_o  = r_valid_r;
  assign r_id_o     = r_id_r;
  assign r_data_o   = r_data_r;
  assign r_resp_o   = r_resp_r;
  assign r_last_o   = r_last_r;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default parameters).
module tb_axi_mem_responder;

  logic         clk_i, rstn_i;
  logic         aw_valid_i, aw_ready_o;
  logic [5:0]   aw_id_i;
  logic [63:0]  aw_addr_i;
  logic [7:0]   aw_len_i;
  logic         w_valid_i, w_ready_o;
  logic [511:0] w_data_i;
  logic [63:0]  w_strb_i;
  logic         w_last_i;
  logic         b_valid_o, b_ready_i;
  logic [5:0]   b_id_o;
  logic [1:0]   b_resp_o;
  logic         ar_valid_i, ar_ready_o;
  logic [5:0]   ar_id_i;
  logic [63:0]  ar_addr_i;
  logic [7:0]   ar_len_i;
  logic         r_valid_o, r_ready_i;
  logic [5:0]   r_id_o;
  logic [511:0] r_data_o;
  logic [1:0]   r_resp_o;
  logic         r_last_o;

  int tests_run_r = 0;
  int fails_r     = 0;

  logic [511:0] wr_data_q [16];
  logic [511:0] rd_data_q [16];
  logic [1:0]   rd_resp_q [16];
  logic         rd_last_q [16];
  logic [5:0]   rd_id_q;
  logic [1:0]   b_resp_got;
  logic [5:0]   b_id_got;
  logic [511:0] exp_s;

  axi_mem_responder dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [511:0] pat(input logic [31:0] x);
    return {16{x}};
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests_run_r++;
    if (got !== exp) begin
      fails_r++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [63:0] strb, input int last_at, input int b_hold);
    int n;
    logic hold_ok;
    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
    n = 0;
    while (!aw_ready_o && n < 50) begin @(negedge clk_i); n++; end
    check("aw_timeout", 512'(n < 50), 512'd1);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid_i = 1'b1; w_data_i = wr_data_q[i]; w_strb_i = strb; w_last_i = (i == last_at);
      n = 0;
      while (!w_ready_o && n < 50) begin @(negedge clk_i); n++; end
      check("w_timeout", 512'(n < 50), 512'd1);
      @(negedge clk_i);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    n = 0;
    while (!b_valid_o && n < 50) begin @(negedge clk_i); n++; end
    check("b_timeout", 512'(n < 50), 512'd1);
    hold_ok = 1'b1;
    for (int k = 0; k < b_hold; k++) begin
      @(negedge clk_i);
      hold_ok &= b_valid_o;
    end
    if (b_hold > 0) check("b_held", 512'(hold_ok), 512'd1);
    b_resp_got = b_resp_o; b_id_got = b_id_o;
    b_ready_i = 1'b1;
    @(negedge clk_i);
    b_ready_i = 1'b0;
    check("aw_ready_after_b", 512'(aw_ready_o), 512'd1);
  endtask

  task automatic axi_read(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input bit stall);
    int n;
    ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
    n = 0;
    while (!ar_ready_o && n < 50) begin @(negedge clk_i); n++; end
    check("ar_timeout", 512'(n < 50), 512'd1);
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    check("r_first_latency", 512'(r_valid_o), 512'd1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!r_valid_o && n < 50) begin @(negedge clk_i); n++; end
      check("r_timeout", 512'(n < 50), 512'd1);
      if (i > 0) check("r_no_bubble", 512'(n), 512'd0);
      rd_data_q[i] = r_data_o; rd_resp_q[i] = r_resp_o; rd_last_q[i] = r_last_o; rd_id_q = r_id_o;
      if (stall) begin
        r_ready_i = 1'b0;
        @(negedge clk_i);
        check("r_hold_data", r_data_o, rd_data_q[i]);
        check("r_hold_valid", 512'(r_valid_o), 512'd1);
      end
      r_ready_i = 1'b1;
      @(negedge clk_i);
      r_ready_i = 1'b0;
    end
    check("r_done_valid", 512'(r_valid_o), 512'd0);
    check("r_done_ar_ready", 512'(ar_ready_o), 512'd1);
  endtask

  initial begin
    rstn_i = 1'b0;
    aw_valid_i = 1'b0; aw_id_i = 6'd0; aw_addr_i = 64'd0; aw_len_i = 8'd0;
    w_valid_i = 1'b0; w_data_i = 512'd0; w_strb_i = 64'd0; w_last_i = 1'b0;
    b_ready_i = 1'b0;
    ar_valid_i = 1'b0; ar_id_i = 6'd0; ar_addr_i = 64'd0; ar_len_i = 8'd0;
    r_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);

    check("rst_aw_ready", 512'(aw_ready_o), 512'd1);
    check("rst_ar_ready", 512'(ar_ready_o), 512'd1);
    check("rst_w_ready",  512'(w_ready_o),  512'd0);
    check("rst_b_valid",  512'(b_valid_o),  512'd0);
    check("rst_r_valid",  512'(r_valid_o),  512'd0);
    check("rst_r_last",   512'(r_last_o),   512'd0);
    check("rst_ids",      512'({b_id_o, r_id_o}), 512'd0);
    check("rst_resps",    512'({b_resp_o, r_resp_o}), 512'd0);
    check("rst_r_data",   r_data_o, 512'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Single-beat write then read back.
    wr_data_q[0] = pat(32'hA0A0_0001);
    axi_write(6'd3, 64'h40, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    check("t1_b_id", 512'(b_id_got), 512'd3);
    check("t1_b_resp", 512'(b_resp_got), 512'd0);
    axi_read(6'd5, 64'h40, 8'd0, 1'b0);
    check("t1_r_id", 512'(rd_id_q), 512'd5);
    check("t1_r_data", rd_data_q[0], pat(32'hA0A0_0001));
    check("t1_r_last", 512'(rd_last_q[0]), 512'd1);
    check("t1_r_resp", 512'(rd_resp_q[0]), 512'd0);

    // Four-beat burst, read back with r_ready toggling.
    for (int i = 0; i < 4; i++) wr_data_q[i] = pat(32'h100 + 32'(i));
    axi_write(6'd1, 64'h1000, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0);
    check("t2_b_resp", 512'(b_resp_got), 512'd0);
    axi_read(6'd2, 64'h1000, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t2_r_data", rd_data_q[i], pat(32'h100 + 32'(i)));
      check("t2_r_last", 512'(rd_last_q[i]), 512'(i == 3));
    end

    // Partial strobe over an all-ones word.
    wr_data_q[0] = {512{1'b1}};
    axi_write(6'd4, 64'h2000, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    wr_data_q[0] = pat(32'h1234_5678);
    axi_write(6'd4, 64'h2000, 8'd0, 64'h0000_0000_0000_000F, 0, 0);
    axi_read(6'd6, 64'h2000, 8'd0, 1'b0);
    check("t3_partial", rd_data_q[0], {{480{1'b1}}, 32'h1234_5678});

    // Same-cycle AW and AR, B held off for 10 cycles.
    wr_data_q[0] = pat(32'h3030_3030);
    fork
      axi_write(6'd9, 64'h3000, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 10);
      axi_read(6'd12, 64'h1000, 8'd0, 1'b0);
    join
    check("t4_b_id", 512'(b_id_got), 512'd9);
    check("t4_b_resp", 512'(b_resp_got), 512'd0);
    check("t4_r_id", 512'(rd_id_q), 512'd12);
    check("t4_r_data", rd_data_q[0], pat(32'h100));
    axi_read(6'd13, 64'h3000, 8'd0, 1'b0);
    check("t4_readback", rd_data_q[0], pat(32'h3030_3030));

    // Reset during beat 2 of a 4-beat read.
    ar_valid_i = 1'b1; ar_id_i = 6'd7; ar_addr_i = 64'h1000; ar_len_i = 8'd3;
    @(negedge clk_i);
    ar_valid_i = 1'b0; r_ready_i = 1'b1;
    @(negedge clk_i);
    r_ready_i = 1'b0;
    check("t5_beat2_valid", 512'(r_valid_o), 512'd1);
    check("t5_beat2_data", r_data_o, pat(32'h101));
    rstn_i = 1'b0;
    #1;
    check("t5_rst_r_valid", 512'(r_valid_o), 512'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("t5_ar_ready", 512'(ar_ready_o), 512'd1);
    axi_read(6'd8, 64'h40, 8'd0, 1'b0);
    check("t5_after_rst", rd_data_q[0], pat(32'hA0A0_0001));
    check("t5_after_rst_id", 512'(rd_id_q), 512'd8);

    // Address beyond the array.
    wr_data_q[0] = pat(32'h7777_0000);
    axi_write(6'd10, 64'h0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    axi_read(6'd11, 64'h1_0000, 8'd0, 1'b0);
`ifdef AXI_MEM_RESP_OOR_ERR_EN
    exp_s = 512'd0;
    check("t6_oor_resp", 512'(rd_resp_q[0]), 512'd2);
`else
    exp_s = pat(32'h7777_0000);
    check("t6_oor_resp", 512'(rd_resp_q[0]), 512'd0);
`endif
    check("t6_oor_data", rd_data_q[0], exp_s);

    // Early w_last: beat count still governs, response is SLVERR.
    wr_data_q[0] = pat(32'h50); wr_data_q[1] = pat(32'h51);
    axi_write(6'd14, 64'h5000, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    check("t7_b_resp", 512'(b_resp_got), 512'd2);
    check("t7_b_id", 512'(b_id_got), 512'd14);
    axi_read(6'd15, 64'h5000, 8'd1, 1'b0);
    check("t7_beat0", rd_data_q[0], pat(32'h50));
    check("t7_beat1", rd_data_q[1], pat(32'h51));
    check("t7_last", 512'({rd_last_q[0], rd_last_q[1]}), 512'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run_r, fails_r);
    $finish;
  end

endmodule
